// File: rtl/beam_scan_ctrl_if.sv
// beam_scan_ctrl_if -- control and ROM/datapath signals of the beam scan controller.
//   start/abort/num_angles : sweep request and cancel from the requester
//   sv_addr/sv_en          : steering-vector ROM read port
//   pow_in                 : beam power returned by the datapath
//   busy/done              : sweep status, done is a one-cycle result strobe
//   best_pow/best_idx      : maximum power and its angle index of the last sweep
// master: requester/datapath side; slave: the controller.
interface beam_scan_ctrl_if #(
  parameter int ANGLE_BITS = 8,
  parameter int POW_WIDTH  = 54
);
  logic                  start;
  logic                  abort;
  logic [ANGLE_BITS:0]   num_angles;
  logic [ANGLE_BITS-1:0] sv_addr;
  logic                  sv_en;
  logic [POW_WIDTH-1:0]  pow_in;
  logic                  busy;
  logic                  done;
  logic [POW_WIDTH-1:0]  best_pow;
  logic [ANGLE_BITS-1:0] best_idx;

  modport master (
    output start, abort, num_angles, pow_in,
    input  sv_addr, sv_en, busy, done, best_pow, best_idx
  );

  modport slave (
    input  start, abort, num_angles, pow_in,
    output sv_addr, sv_en, busy, done, best_pow, best_idx
  );
endinterface

// File: rtl/beam_scan_ctrl.sv
// beam_scan_ctrl -- sweeps N steering-vector addresses, one per cycle, and tracks
// the angle with the largest returned beam power.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : beam_scan_ctrl_if slave modport (start/abort/num_angles in, ROM
//         address/enable out, pow_in in, busy/done/best_pow/best_idx out)
// pow_in for the issue made at cycle t is sampled at cycle t+1+DP_LAT
// (1-cycle ROM read plus DP_LAT datapath registers).
module beam_scan_ctrl #(
  parameter int ANGLE_BITS = 8,
  parameter int POW_WIDTH  = 54,
  parameter int DP_LAT     = 2
) (
  input logic             clk,
  input logic             rst,
  beam_scan_ctrl_if.slave bus
);

  localparam int L = 1 + DP_LAT;
  localparam logic [ANGLE_BITS:0] N_MAX = {1'b1, {ANGLE_BITS{1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [ANGLE_BITS:0]   n_lat;
  logic [ANGLE_BITS:0]   n_sat;
  logic [ANGLE_BITS-1:0] addr;
  logic                  last_issue;
  logic [L-1:0]          vld;
  logic [L-1:0]          vld_next;
  logic [ANGLE_BITS-1:0] tag [L];
  logic [POW_WIDTH-1:0]  best_pow;
  logic [ANGLE_BITS-1:0] best_idx;
  logic                  issuing;
  logic                  active;

  assign issuing = (state == SWEEP);
  assign active  = (state == SWEEP) || (state == DRAIN);

  assign bus.sv_en    = issuing;
  assign bus.sv_addr  = issuing ? addr : '0;
  assign bus.busy     = active;
  assign bus.done     = (state == DONE);
  assign bus.best_pow = best_pow;
  assign bus.best_idx = best_idx;

  always_comb begin
    n_sat      = (bus.num_angles > N_MAX) ? N_MAX : bus.num_angles;
    last_issue = ({1'b0, addr} == (n_lat - 1'b1));
  end

  // Occupancy of the in-flight line after the coming edge; the sweep is drained
  // once nothing would remain in it.
  always_comb begin
    vld_next    = '0;
    vld_next[0] = issuing;
    for (int unsigned i = 1; i < L; i++) begin
      vld_next[i] = vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_lat    <= '0;
      addr     <= '0;
      vld      <= '0;
      best_pow <= '0;
      best_idx <= '0;
    end else begin
      vld    <= vld_next;
      tag[0] <= addr;
      for (int unsigned i = 1; i < L; i++) begin
        tag[i] <= tag[i-1];
      end

      // Index 0 always loads so a sweep of all-zero powers still reports index 0.
      if (vld[L-1] && !(active && bus.abort)) begin
        if ((tag[L-1] == '0) || (bus.pow_in > best_pow)) begin
          best_pow <= bus.pow_in;
          best_idx <= tag[L-1];
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            n_lat    <= n_sat;
            addr     <= '0;
            best_pow <= '0;
            best_idx <= '0;
            state    <= (n_sat == '0) ? DONE : SWEEP;
          end
        end
        SWEEP: begin
          if (bus.abort) begin
            state <= IDLE;
            vld   <= '0;
          end else if (last_issue) begin
            state <= DRAIN;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.abort) begin
            state <= IDLE;
            vld   <= '0;
          end else if (vld_next == '0) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// tb_beam_scan_ctrl -- directed and randomized sweeps of beam_scan_ctrl, checked
// cycle by cycle against expectations derived from sweep length and power table.
module tb_beam_scan_ctrl;
  localparam int AB  = 8;
  localparam int PW  = 54;
  localparam int DPL = 2;
  localparam int L   = 1 + DPL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beam_scan_ctrl_if #(.ANGLE_BITS(AB), .POW_WIDTH(PW)) bus ();

  beam_scan_ctrl #(.ANGLE_BITS(AB), .POW_WIDTH(PW), .DP_LAT(DPL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [PW-1:0] pows [256];

  function automatic logic [PW-1:0] rnd_pow();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[PW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start at the current cycle (cycle 0). abort_cyc/rst_cyc > 0 cut the sweep
  // at that cycle; restart_cyc > 0 pulses a start that must be ignored.
  task automatic sweep(input int n, input int abort_cyc, input int rst_cyc, input int restart_cyc);
    int ne, dc, last, bi, cut;
    logic [PW-1:0] bp;
    ne = (n > (1 << AB)) ? (1 << AB) : n;
    dc = (ne == 0) ? 1 : ne + L + 1;
    bp = '0;
    bi = 0;
    for (int k = 0; k < ne; k++) begin
      if (k == 0 || pows[k] > bp) begin
        bp = pows[k];
        bi = k;
      end
    end
    cut  = (abort_cyc > 0) ? abort_cyc : rst_cyc;
    last = (cut > 0) ? cut + 1 : dc + 1;

    chk("idle_busy", bus.busy, 0);
    chk("idle_sv_en", bus.sv_en, 0);
    bus.start      = 1'b1;
    bus.abort      = 1'($urandom_range(0, 1));
    bus.num_angles = (AB+1)'(n);
    bus.pow_in     = rnd_pow();
    tick();
    for (int c = 1; c <= last; c++) begin
      int k;
      bit dead;
      bit exp_en;
      bus.start      = (c == restart_cyc);
      bus.num_angles = (AB+1)'($urandom);
      bus.abort      = (c == abort_cyc);
      rst            = (c == rst_cyc);
      k = c - 1 - L;
      bus.pow_in = (k >= 0 && k < ne) ? pows[k] : rnd_pow();
      dead   = (cut > 0) && (c > cut);
      exp_en = !dead && (c <= ne);
      chk("sv_en", bus.sv_en, exp_en);
      chk("sv_addr", bus.sv_addr, exp_en ? c - 1 : 0);
      chk("busy", bus.busy, !dead && (c < dc));
      chk("done", bus.done, !dead && (c == dc));
      if (!dead && c >= dc) begin
        chk("best_pow", bus.best_pow, bp);
        chk("best_idx", bus.best_idx, bi);
      end
      if (rst_cyc > 0 && dead) begin
        chk("rst_best_pow", bus.best_pow, 0);
        chk("rst_best_idx", bus.best_idx, 0);
      end
      if (!(rst_cyc > 0 && c == last)) tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.num_angles = '0;
    bus.pow_in     = '0;
    rst            = 1'b1;
    bus.start      = 1'b1;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sv_en", bus.sv_en, 0);
    chk("rst_sv_addr", bus.sv_addr, 0);
    chk("rst_best_pow", bus.best_pow, 0);
    chk("rst_best_idx", bus.best_idx, 0);
    rst       = 1'b0;
    bus.start = 1'b0;

    pows[0] = 5; pows[1] = 9; pows[2] = 3; pows[3] = 7;
    sweep(4, 0, 0, 0);

    pows[0] = 4; pows[1] = 8; pows[2] = 8;
    sweep(3, 0, 0, 0);

    sweep(0, 0, 0, 0);

    for (int k = 0; k < 256; k++) pows[k] = rnd_pow();
    sweep(8, 3, 0, 0);
    sweep(8, 0, 0, 0);

    pows[0] = 5; pows[1] = 9; pows[2] = 3; pows[3] = 7;
    sweep(4, 0, 0, 2);

    for (int k = 0; k < 256; k++) pows[k] = rnd_pow();
    sweep(16, 0, 5, 0);
    sweep(5, 0, 0, 0);

    sweep(300, 0, 0, 0);

    for (int k = 0; k < 256; k++) pows[k] = '0;
    sweep(6, 0, 0, 0);
    sweep(1, 0, 0, 0);

    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 256; k++) begin
        pows[k] = (t % 2 == 0) ? PW'($urandom_range(0, 15)) : rnd_pow();
      end
      sweep($urandom_range(1, 40), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/beam_scan_ctrl.md
BEAM_SCAN_CTRL -- requirements
Module: beam_scan_ctrl

Interface
REQ-001 The block SHALL have parameter ANGLE_BITS, default 8, which sets the width of the angle index and the steering-vector address.
REQ-002 The block SHALL have parameter POW_WIDTH, default 54, which sets the width of the power word returned by the abs-squared complex-multiply datapath.
REQ-003 The block SHALL have parameter DP_LAT, default 2, which is the datapath register latency in cycles from steering vector present to power valid.
REQ-004 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high, named rst.
REQ-005 Port clk: input, 1 bit, system clock; all logic rising-edge.
REQ-006 Port rst: input, 1 bit, synchronous active-high reset.
REQ-007 Port start: input, 1 bit, single-cycle request to begin a sweep.
REQ-008 Port abort: input, 1 bit, terminates the sweep; no result is reported.
REQ-009 Port num_angles: input, ANGLE_BITS+1 bits, number of angles N to sweep; sampled only on an accepted start.
REQ-010 Port sv_addr: output, ANGLE_BITS bits, steering-vector ROM address (ROM has 1-cycle read latency).
REQ-011 Port sv_en: output, 1 bit, ROM read enable, high when sv_addr is a valid issue.
REQ-012 Port pow_in: input, POW_WIDTH bits, unsigned beam power from the datapath.
REQ-013 Port busy: output, 1 bit, high from an accepted start until done or abort.
REQ-014 Port done: output, 1 bit, single-cycle pulse marking a valid result.
REQ-015 Port best_pow: output, POW_WIDTH bits, maximum power of the last completed sweep.
REQ-016 Port best_idx: output, ANGLE_BITS bits, angle index of best_pow.

Function
REQ-017 FSM states SHALL be IDLE, SWEEP, DRAIN and DONE.
- IDLE->SWEEP on start with N>0.
- IDLE->DONE on start with N=0.
- SWEEP->DRAIN after index N-1 is issued.
- DRAIN->DONE when no result is in flight.
- DONE->IDLE unconditionally, after one cycle.
REQ-018 start SHALL be accepted only in IDLE; start while busy is ignored, with no effect on the sweep or on num_angles capture.
REQ-019 On accepted start, best_pow SHALL clear to 0, best_idx to 0, and N latches.
REQ-020 Issue timing: with start accepted at cycle 0, index k SHALL be driven on sv_addr with sv_en=1 at cycle 1+k, for k=0..N-1, one per cycle with no gaps.
REQ-021 sv_en SHALL be 0 and sv_addr SHALL hold 0 whenever not issuing.
REQ-022 An internal valid/index shift line of depth L=1+DP_LAT SHALL track in-flight issues.
- Index k's pow_in is sampled at cycle 1+k+L.
REQ-023 On each sampled result, if pow_in > best_pow (strictly greater, unsigned), best_pow SHALL be loaded with pow_in and best_idx with k.
- Ties SHALL keep the lowest index.
REQ-024 Index 0's result SHALL always load best_pow and best_idx, including pow_in=0.
REQ-025 done SHALL pulse for exactly 1 cycle, at cycle N+L+1 for N>0 and at cycle 1 for N=0; busy SHALL fall in the same cycle done is high.
REQ-026 For N=0, best_pow and best_idx SHALL report 0.
REQ-027 best_pow and best_idx SHALL hold their values from done until the next accepted start.
REQ-028 abort in SWEEP or DRAIN SHALL, on the next edge, go to IDLE, flush the shift line, and deassert sv_en and busy; done SHALL NOT pulse.
- best_pow and best_idx are then undefined until the next done.
REQ-029 abort in IDLE or DONE SHALL be ignored.
REQ-030 When abort and start are both high in IDLE, start SHALL win.
REQ-031 N SHALL be limited to 2^ANGLE_BITS; larger values SHALL saturate to 2^ANGLE_BITS.
REQ-032 sv_addr SHALL never wrap within a sweep.

Reset
REQ-033 rst SHALL take priority over all inputs, including start and abort.
REQ-034 On rst the block SHALL go to IDLE with busy=0, done=0, sv_en=0, sv_addr=0, best_pow=0 and best_idx=0, and the shift line cleared.
REQ-035 rst asserted mid-sweep SHALL cancel the sweep with no done pulse.
REQ-036 The first start SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-037 Basic sweep, DP_LAT=2 (L=3), N=4, pow_in per index {5,9,3,7}, start at cycle 0 -> sv_addr 0..3 at cycles 1..4; done at cycle 8; best_pow=9, best_idx=1; busy high cycles 1..7.
REQ-038 Tie, N=3, pow {4,8,8} -> best_idx=1, best_pow=8.
REQ-039 N=0 -> done at cycle 1; sv_en never high; best_pow=0, best_idx=0.
REQ-040 Abort at cycle 3 of an N=8 sweep -> sv_en low from cycle 4; busy low at cycle 4; no done.
- A following start at cycle 5 SHALL run a clean sweep.
REQ-041 Start pulsed at cycle 2 of a running N=4 sweep -> ignored; single done at cycle 8.
REQ-042 rst at cycle 5 of an N=16 sweep -> at the next cycle, all outputs 0 and no done.
- num_angles=300 with ANGLE_BITS=8 -> 256 issues, last sv_addr=255.
